// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780 text driver: FSM encodings, the init
// command table, DDRAM line addresses and the line geometry.
package lcd_pkg;

  localparam logic [2:0] PWR_WAIT = 3'd0;
  localparam logic [2:0] INIT     = 3'd1;
  localparam logic [2:0] ADDR1    = 3'd2;
  localparam logic [2:0] CHAR1    = 3'd3;
  localparam logic [2:0] ADDR2    = 3'd4;
  localparam logic [2:0] CHAR2    = 3'd5;

  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_SETUP  = 2'd1;
  localparam logic [1:0] PH_E_HIGH = 2'd2;
  localparam logic [1:0] PH_SETTLE = 2'd3;

  localparam logic [7:0] LINE1_ADDR = 8'h80;
  localparam logic [7:0] LINE2_ADDR = 8'hC0;

  localparam int CHARS_PER_LINE = 16;
  localparam int INIT_LEN       = 4;

  // 8-bit bus / 2 lines, display on, entry increment, clear display.
  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// One bus write: SETUP (1 clk), E_HIGH (T_EH clk), SETTLE (T_CMD or T_CLR clk).
// The delay counter lives in the parent; this block requests reloads of it.
module lcd_write_strobe
  import lcd_pkg::*;
#(
  parameter int T_EH  = 50,
  parameter int T_CMD = 2_500,
  parameter int T_CLR = 100_000,
  parameter int CW    = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          rs,
  input  logic [7:0]    data,
  input  logic          long_settle,
  input  logic          cnt_zero,
  output logic          done,
  output logic          settle_entry,
  output logic          load,
  output logic [CW-1:0] load_val,
  output logic          lcd_e,
  output logic          lcd_rs,
  output logic [7:0]    lcd_data
);

  logic [1:0] phase;
  logic       long_q;

  always_comb begin
    done         = (phase == PH_SETTLE) && cnt_zero;
    settle_entry = (phase == PH_E_HIGH) && cnt_zero;
    load         = (phase == PH_SETUP) || settle_entry;
    if (phase == PH_SETUP) load_val = CW'(T_EH - 1);
    else if (long_q)       load_val = CW'(T_CLR - 1);
    else                   load_val = CW'(T_CMD - 1);
  end

  // A start arriving on the last SETTLE cycle chains straight into SETUP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase    <= PH_IDLE;
      long_q   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
    end else begin
      case (phase)
        PH_SETUP: begin
          phase <= PH_E_HIGH;
          lcd_e <= 1'b1;
        end
        PH_E_HIGH: if (cnt_zero) begin
          phase <= PH_SETTLE;
          lcd_e <= 1'b0;
        end
        default: if (phase == PH_IDLE || cnt_zero) begin
          if (start) begin
            phase    <= PH_SETUP;
            lcd_rs   <= rs;
            lcd_data <= data;
            long_q   <= long_settle;
          end else begin
            phase <= PH_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/lcd_text_driver.sv
// HD44780 8-bit text driver: power-on wait, init sequence, then endless
// refresh of two 16-character lines fetched from a mode page via index.
module lcd_text_driver
  import lcd_pkg::*;
#(
  parameter int T_PWR = 1_000_000,
  parameter int T_EH  = 50,
  parameter int T_CMD = 2_500,
  parameter int T_CLR = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [4:0] index,
  input  logic [7:0] char_in,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       busy
);

  localparam int CNT_MAX = (T_PWR > T_CLR) ? T_PWR : T_CLR;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [1:0] INIT_LAST   = 2'(INIT_LEN - 1);
  localparam logic [4:0] LINE2_FIRST = 5'(CHARS_PER_LINE);

  logic [2:0]    state;
  logic [1:0]    init_ptr;
  logic [CW-1:0] cnt;
  logic          cnt_zero;
  logic          start, wr_rs, wr_long;
  logic [7:0]    wr_data;
  logic          done, settle_entry, load;
  logic [CW-1:0] load_val;

  assign cnt_zero = (cnt == '0);
  assign lcd_rw   = 1'b0;

  // Line ends are detected from index, which has already advanced past the
  // last character by the time that write completes.
  always_comb begin
    start   = 1'b0;
    wr_rs   = 1'b0;
    wr_data = '0;
    wr_long = 1'b0;
    case (state)
      PWR_WAIT: if (cnt_zero) begin
        start   = 1'b1;
        wr_data = init_cmd(2'd0);
      end
      INIT: if (done) begin
        start = 1'b1;
        if (init_ptr == INIT_LAST) begin
          wr_data = LINE1_ADDR;
        end else begin
          wr_data = init_cmd(init_ptr + 2'd1);
          wr_long = ((init_ptr + 2'd1) == INIT_LAST);
        end
      end
      ADDR1, ADDR2: if (done) begin
        start   = 1'b1;
        wr_rs   = 1'b1;
        wr_data = char_in;
      end
      CHAR1: if (done) begin
        start = 1'b1;
        if (index == LINE2_FIRST) begin
          wr_data = LINE2_ADDR;
        end else begin
          wr_rs   = 1'b1;
          wr_data = char_in;
        end
      end
      CHAR2: if (done) begin
        start = 1'b1;
        if (index == '0) begin
          wr_data = LINE1_ADDR;
        end else begin
          wr_rs   = 1'b1;
          wr_data = char_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= PWR_WAIT;
      init_ptr <= '0;
      index    <= '0;
      busy     <= 1'b1;
      cnt      <= CW'(T_PWR);
    end else begin
      if (load)          cnt <= load_val;
      else if (!cnt_zero) cnt <= cnt - CW'(1);

      if (settle_entry && (state == CHAR1 || state == CHAR2))
        index <= index + 5'd1;

      if (start) begin
        case (state)
          PWR_WAIT: state <= INIT;
          INIT: begin
            if (init_ptr == INIT_LAST) begin
              state <= ADDR1;
              busy  <= 1'b0;
            end else begin
              init_ptr <= init_ptr + 2'd1;
            end
          end
          ADDR1: state <= CHAR1;
          ADDR2: state <= CHAR2;
          CHAR1: if (index == LINE2_FIRST) state <= ADDR2;
          CHAR2: if (index == '0) state <= ADDR1;
          default: state <= PWR_WAIT;
        endcase
      end
    end
  end

  lcd_write_strobe #(
    .T_EH (T_EH),
    .T_CMD(T_CMD),
    .T_CLR(T_CLR),
    .CW   (CW)
  ) u_strobe (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rs          (wr_rs),
    .data        (wr_data),
    .long_settle (wr_long),
    .cnt_zero    (cnt_zero),
    .done        (done),
    .settle_entry(settle_entry),
    .load        (load),
    .load_val    (load_val),
    .lcd_e       (lcd_e),
    .lcd_rs      (lcd_rs),
    .lcd_data    (lcd_data)
  );

endmodule

// File: doc/lcd_text_driver.md
LCD_TEXT_DRIVER -- requirements
Module: lcd_text_driver

Interface
REQ-001 SHALL have parameter T_PWR, default 1_000_000, power-on wait in clk cycles (20 ms @ 50 MHz).
REQ-002 SHALL have parameter T_EH, default 50, lcd_e high width in clk cycles.
REQ-003 SHALL have parameter T_CMD, default 2_500, post-write settle in clk cycles (50 us).
REQ-004 SHALL have parameter T_CLR, default 100_000, settle after clear-display (0x01) in clk cycles.
REQ-005 SHALL have ports: clk in 1 system clock; rst in 1 reset; one clock, reset asynchronous and active-low.
REQ-006 SHALL have port index out 5 character position requested from the mode page (0-15 line 1, 16-31 line 2).
REQ-007 SHALL have port char_in in 8 ASCII code returned by the mode page for index, valid 1 clk after index changes.
REQ-008 SHALL have ports lcd_e out 1 enable strobe; lcd_rs out 1 (0 command, 1 data); lcd_rw out 1 tied 0.
REQ-009 SHALL have port lcd_data out 8 HD44780 8-bit data bus.
REQ-010 SHALL have port busy out 1, high while in power-on wait or init sequence.

Function
REQ-011 SHALL use FSM states PWR_WAIT, INIT, ADDR1, CHAR1, ADDR2, CHAR2, with each write running sub-phases SETUP(1 clk), E_HIGH(T_EH), SETTLE(T_CMD or T_CLR).
REQ-012 SHALL stay in PWR_WAIT for T_PWR cycles after reset release, with all outputs at reset values.
REQ-013 SHALL have INIT issue, in order, 0x38, 0x0C, 0x06, 0x01 with lcd_rs=0, using T_CLR settle after 0x01 only.
REQ-014 SHALL have ADDR1 write 0x80 (rs=0) and CHAR1 write 16 data bytes (rs=1) for index 0..15.
REQ-015 SHALL have ADDR2 write 0xC0 (rs=0) and CHAR2 write 16 data bytes for index 16..31.
REQ-016 SHALL go from CHAR2 after index 31 to ADDR1 with index wrapping to 0, refreshing continuously and never re-entering INIT except via reset.
REQ-017 SHALL drive index to the next position at the start of SETTLE of the previous write and sample char_in into lcd_data at SETUP, so at least 2 clk elapse between index change and sampling.
REQ-018 SHALL keep lcd_data and lcd_rs stable from SETUP through the end of E_HIGH, with lcd_e high for exactly T_EH cycles per write.
REQ-019 SHALL deassert busy on the first cycle of ADDR1 and never reassert it until reset.
REQ-020 SHALL use a single down-counter sized for max(T_PWR,T_CLR) (20 bits at defaults) for all delays, reloaded on every phase entry and never wrapping.
REQ-021 SHALL write char_in values unfiltered, including 0x20 blink spaces.

Reset
REQ-022 SHALL, on rst low at any time (including mid-write or with lcd_e high), immediately set state=PWR_WAIT, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, index=0, busy=1, counter=T_PWR.
REQ-023 SHALL, after reset release, restart the full power-on and INIT sequence from the first step.

Structure
REQ-024 SHALL place the shared package lcd_pkg contents there: FSM state encoding, init command table (0x38,0x0C,0x06,0x01), line address constants 0x80/0xC0, and the count 16 chars/line.
REQ-025 SHALL use a single sub-module lcd_write_strobe performing one SETUP/E_HIGH/SETTLE write (start, rs, data, long_settle in; done out); the top FSM sequences it.

Verification (T_PWR=20, T_EH=3, T_CMD=5, T_CLR=10)
REQ-026 SHALL cover: release reset -> lcd_e stays 0 for 20 clk, then four writes 0x38,0x0C,0x06,0x01 with rs=0, a 10-clk gap after 0x01 only, and busy falls at ADDR1.
REQ-027 SHALL cover: stub mode page returning 0x41+index one clk after index -> lcd_data 0x80, then 0x41..0x50 (rs=1), then 0xC0, then 0x51..0x60, repeating.
REQ-028 SHALL cover: each write -> lcd_e high exactly 3 clk, lcd_data/lcd_rs unchanged during E_HIGH, and index changed at least 2 clk before sampling.
REQ-029 SHALL cover: index 31 written -> next write 0x80 rs=0 with index=0, and no init commands reissued.
REQ-030 SHALL cover: assert rst during the E_HIGH of the 5th data byte -> lcd_e=0, index=0, busy=1 on the same edge, then after release the full 20-clk wait and INIT repeat.
REQ-031 SHALL cover: char_in toggling 0x20/0x32 each clk -> lcd_data equals the value present at SETUP, held constant through E_HIGH.
